// File: rtl/noc_fp_pkg.sv
// Shared types and helpers for the NoC fabric injection port.
// Flit layout is {head, tail, dest, payload} with head at the MSB.
package noc_fp_pkg;

    localparam int FP_MOD_WIDTH  = 320;
    localparam int FP_FLIT_DATA  = 150;
    localparam int FP_DEST_WIDTH = 4;
    localparam int FP_HDR_BITS   = 2;

    typedef struct packed {
        logic                     head;
        logic                     tail;
        logic [FP_DEST_WIDTH-1:0] dest;
        logic [FP_FLIT_DATA-1:0]  payload;
    } flit_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fp_state_e;

    function automatic int num_flits(input int mod_w, input int flit_d);
        return (mod_w + flit_d - 1) / flit_d;
    endfunction

endpackage

// File: rtl/noc_fp_fifo.sv
// Synchronous FIFO holding {dest, data} module words for the port.
// Count is registered; push when full and pop when empty are ignored.
module noc_fp_fifo
    import noc_fp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/noc_fabric_port_in.sv
// NoC injection port: buffers wide module words and serializes them
// into credit-limited router flits with head/tail/dest fields.
module noc_fabric_port_in
    import noc_fp_pkg::*;
#(
    parameter int MOD_WIDTH  = FP_MOD_WIDTH,
    parameter int FLIT_DATA  = FP_FLIT_DATA,
    parameter int DEST_WIDTH = FP_DEST_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 8,
    localparam int NUM_FLITS = num_flits(MOD_WIDTH, FLIT_DATA),
    localparam int FLIT_W    = FLIT_DATA + DEST_WIDTH + FP_HDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MOD_WIDTH-1:0]  in_data,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_W-1:0]     flit_out,
    output logic                  flit_valid,
    input  logic                  credit_in,
    output logic                  credit_err,
    output logic                  busy
);

    localparam int PAD_W = NUM_FLITS * FLIT_DATA;
    localparam int IDX_W = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam int CRW   = $clog2(CREDITS + 1);
    localparam int FFW   = DEST_WIDTH + MOD_WIDTH;
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                  head;
        logic                  tail;
        logic [DEST_WIDTH-1:0] dest;
        logic [FLIT_DATA-1:0]  payload;
    } flit_s;

    fp_state_e             r_state;
    fp_state_e             w_state_n;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_n;
    logic [PAD_W-1:0]      r_word;
    logic [DEST_WIDTH-1:0] r_dest;
    flit_s                 r_flit;
    flit_s                 w_flit;
    logic                  r_flit_valid;
    logic [CRW-1:0]        r_credits;
    logic                  r_credit_err;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_fire;
    logic                  w_last;
    logic                  w_has_credit;
    logic [FFW-1:0]        w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic [FCW-1:0]        w_fifo_count;

    assign in_ready   = !w_full && !rst;
    assign w_push     = in_valid && in_ready;
    assign flit_out   = r_flit;
    assign flit_valid = r_flit_valid;
    assign credit_err = r_credit_err;
    assign busy       = (w_fifo_count != '0) || (r_state != ST_IDLE);

    noc_fp_fifo #(
        .WIDTH (FFW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({in_dest, in_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    // A credit returned this cycle may be spent by the flit issued this cycle
    assign w_has_credit = (r_credits != '0) || credit_in;
    assign w_last       = (r_idx == IDX_W'(NUM_FLITS - 1));

    assign w_flit.head    = (r_idx == '0);
    assign w_flit.tail    = w_last;
    assign w_flit.dest    = r_dest;
    assign w_flit.payload = r_word[FLIT_DATA-1:0];

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_fire    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_load    = 1'b1;
                    w_idx_n   = '0;
                    w_state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_has_credit) begin
                    w_fire = 1'b1;
                    if (w_last) begin
                        w_idx_n = '0;
                        if (!w_empty) begin
                            w_pop  = 1'b1;
                            w_load = 1'b1;
                        end else begin
                            w_state_n = ST_IDLE;
                        end
                    end else begin
                        w_idx_n = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_word       <= '0;
            r_dest       <= '0;
            r_flit       <= '0;
            r_flit_valid <= 1'b0;
            r_credits    <= CRW'(CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_idx        <= w_idx_n;
            r_flit_valid <= w_fire;
            r_flit       <= w_fire ? w_flit : '0;
            // Upper pad bits of the last flit come from zero-extension here
            if (w_load) begin
                r_word <= PAD_W'(w_fifo_data[MOD_WIDTH-1:0]);
                r_dest <= w_fifo_data[FFW-1:MOD_WIDTH];
            end else if (w_fire) begin
                r_word <= r_word >> FLIT_DATA;
            end
            if (credit_in && !w_fire && r_credits == CRW'(CREDITS))
                r_credit_err <= 1'b1;
            else
                r_credits <= r_credits - CRW'(w_fire) + CRW'(credit_in);
        end
    end

endmodule

// File: tb/tb_noc_fabric_port_in.sv
// Self-checking bench for noc_fabric_port_in with a queue-based
// flit model and a credit model driven from observed traffic.
module tb_noc_fabric_port_in;

    localparam int MW = 320;
    localparam int FD = 150;
    localparam int DW = 4;
    localparam int NF = 3;
    localparam int FW = FD + DW + 2;
    localparam int CR = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] in_data = '0;
    logic [DW-1:0] in_dest = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] flit_out;
    logic          flit_valid;
    logic          credit_in;
    logic          credit_err;
    logic          busy;

    logic cpulse = 1'b0;
    logic ret_mode = 1'b0;

    assign credit_in = (ret_mode && flit_valid) || cpulse;

    noc_fabric_port_in dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .credit_in  (credit_in),
        .credit_err (credit_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [FW-1:0] expq[$];
    int m_cred = CR;
    bit m_err = 1'b0;
    int n_flits = 0;
    int run = 0;
    int max_run = 0;
    bit saw_full = 1'b0;

    task automatic chk(input string tag, input logic [FW-1:0] obs,
                       input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] rnd_word();
        logic [MW-1:0] w;
        for (int i = 0; i < MW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Expected flits: word zero-padded to NF*FD bits, sliced LSB first
    function automatic void exp_word(input logic [MW-1:0] d,
                                     input logic [DW-1:0] dst);
        logic [NF*FD-1:0] pad;
        logic [FD-1:0]    pl;
        pad = '0;
        pad[MW-1:0] = d;
        for (int k = 0; k < NF; k++) begin
            pl = FD'(pad >> (k * FD));
            expq.push_back({k == 0, k == NF - 1, dst, pl});
        end
    endfunction

    always @(posedge clk) begin
        bit ci;
        bit rs;
        ci = credit_in;
        rs = rst;
        #1;
        if (rs) begin
            expq.delete();
            m_cred = CR;
            m_err = 1'b0;
            run = 0;
            chk("rst_flit_valid", FW'(flit_valid), FW'(0));
            chk("rst_busy", FW'(busy), FW'(0));
        end else begin
            if (flit_valid) begin
                n_flits++;
                run++;
                if (run > max_run) max_run = run;
                chk("credit_avail", FW'(m_cred > 0 || ci), FW'(1));
                if (expq.size() == 0)
                    chk("flit_unexpected", FW'(expq.size()), FW'(1));
                else
                    chk("flit", flit_out, expq.pop_front());
            end else begin
                run = 0;
            end
            if (ci && !flit_valid && m_cred == CR)
                m_err = 1'b1;
            else
                m_cred = m_cred - int'(flit_valid) + int'(ci);
            chk("credit_err", FW'(credit_err), FW'(m_err));
        end
    end

    task automatic push(input logic [MW-1:0] d, input logic [DW-1:0] dst);
        int n;
        n = 0;
        in_data = d;
        in_dest = dst;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            saw_full = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("push_wait", FW'(n < 100), FW'(1));
        exp_word(d, dst);
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || flit_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", FW'(n < 300), FW'(1));
    endtask

    initial begin
        int n0;
        int n;
        logic [MW-1:0] d0;

        rst = 1'b1;
        cycles(2);
        chk("rst_in_ready", FW'(in_ready), FW'(0));
        chk("rst_flit_out", flit_out, FW'(0));
        chk("rst_err", FW'(credit_err), FW'(0));
        rst = 1'b0;
        cycles(1);
        chk("rel_in_ready", FW'(in_ready), FW'(1));

        d0 = {(MW / 4){4'h1}};
        push(d0, 4'h5);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("lat_t1_idle", FW'(flit_valid), FW'(0));
        @(posedge clk); #1;
        chk("lat_head", FW'({flit_valid, flit_out[FW-1:FW-2]}), FW'(3'b110));
        chk("head_dest", FW'(flit_out[FD+DW-1:FD]), FW'(5));
        chk("head_pl", FW'(flit_out[FD-1:0]), FW'(d0[FD-1:0]));
        @(posedge clk); #1;
        chk("mid_flit", FW'({flit_valid, flit_out[FW-1:FW-2]}), FW'(3'b100));
        @(posedge clk); #1;
        chk("tail_flit", FW'({flit_valid, flit_out[FW-1:FW-2]}), FW'(3'b101));
        chk("tail_pad", FW'(flit_out[FD-1:MW-2*FD]), FW'(0));
        chk("tail_dest", FW'(flit_out[FD+DW-1:FD]), FW'(5));
        @(negedge clk);
        cpulse = 1'b1;
        cycles(3);
        cpulse = 1'b0;
        wait_idle();

        ret_mode = 1'b1;
        max_run = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 7; i++)
            push(rnd_word(), DW'($urandom_range(0, 15)));
        in_valid = 1'b0;
        wait_idle();
        cycles(2);
        chk("b2b_run", FW'(max_run), FW'(21));
        chk("b2b_saw_full", FW'(saw_full), FW'(1));
        ret_mode = 1'b0;

        n0 = n_flits;
        for (int i = 0; i < 3; i++)
            push(rnd_word(), DW'($urandom_range(0, 15)));
        in_valid = 1'b0;
        cycles(20);
        chk("nocred_flits", FW'(n_flits - n0), FW'(8));
        chk("nocred_busy", FW'(busy), FW'(1));
        cpulse = 1'b1;
        @(posedge clk); #1;
        chk("pulse_flit", FW'(flit_valid), FW'(1));
        @(negedge clk);
        cpulse = 1'b0;
        cycles(10);
        chk("pulse_one", FW'(n_flits - n0), FW'(9));
        chk("pulse_idle", FW'(busy), FW'(0));
        cpulse = 1'b1;
        cycles(8);
        cpulse = 1'b0;
        cycles(2);

        chk("err_clear", FW'(credit_err), FW'(0));
        cpulse = 1'b1;
        cycles(1);
        cpulse = 1'b0;
        chk("err_set", FW'(credit_err), FW'(1));
        cycles(5);
        chk("err_sticky", FW'(credit_err), FW'(1));

        push(rnd_word(), DW'($urandom_range(0, 15)));
        in_valid = 1'b0;
        n = 0;
        while (!flit_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pkt_head", FW'({flit_valid, flit_out[FW-1]}), FW'(2'b11));
        rst = 1'b1;
        #1;
        chk("rst2_in_ready", FW'(in_ready), FW'(0));
        @(posedge clk); #1;
        chk("rst2_fv", FW'(flit_valid), FW'(0));
        chk("rst2_busy", FW'(busy), FW'(0));
        chk("rst2_err", FW'(credit_err), FW'(0));
        @(negedge clk);
        rst = 1'b0;
        n0 = n_flits;
        cycles(4);
        chk("rst2_no_tail", FW'(n_flits - n0), FW'(0));
        for (int i = 0; i < 3; i++)
            push(rnd_word(), DW'($urandom_range(0, 15)));
        in_valid = 1'b0;
        cycles(20);
        chk("rst2_credits", FW'(n_flits - n0), FW'(8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
